// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - write/read bus bundle for the parametrised register file
interface regfile_param_if #(
   parameter int WIDTH  = 64,
   parameter int ADDR_W = 5
);
   logic              RegWrite;
   logic [ADDR_W-1:0] WriteRegister;
   logic [WIDTH-1:0]  WriteData;
   logic [ADDR_W-1:0] ReadRegister1;
   logic [ADDR_W-1:0] ReadRegister2;
   logic [WIDTH-1:0]  ReadData1;
   logic [WIDTH-1:0]  ReadData2;
   logic              WriteAck;

   modport master (
      output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      input  ReadData1, ReadData2, WriteAck
   );

   modport slave (
      input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      output ReadData1, ReadData2, WriteAck
   );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - DEPTH x WIDTH register file, two combinational reads, one write, zero reg, bypass
module regfile_param #(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31,
   parameter int BYPASS   = 1
) (
   input logic            clk,
   input logic            reset,
   regfile_param_if.slave bus
);

   // One extra bit so ZERO_REG == DEPTH == 2**ADDR_W (zero register disabled) is representable.
   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] LP_ZERO  = (ADDR_W + 1)'(ZERO_REG);

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic             r_ack;
   logic             w_commit;
   logic [DEPTH-1:0] w_we_dec;
   logic [WIDTH-1:0] w_rd1;
   logic [WIDTH-1:0] w_rd2;

   // Returns the architectural read value of one port, including zero register and bypass.
   function automatic logic [WIDTH-1:0] f_read(input logic [ADDR_W-1:0] a);
      logic [WIDTH-1:0] v;
      v = '0;
      if (reset) begin
         v = '0;
      end else if (({1'b0, a} == LP_ZERO) || ({1'b0, a} >= LP_DEPTH)) begin
         v = '0;
      end else if ((BYPASS != 0) && w_commit && (a == bus.WriteRegister)) begin
         // w_commit already excludes the zero register and out-of-range targets
         v = bus.WriteData;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (a == ADDR_W'(i)) v = r_regs[i];
         end
      end
      return v;
   endfunction

   // Commit condition: enabled write to an in-range, non-zero register.
   always_comb begin
      w_commit = bus.RegWrite &&
                 ({1'b0, bus.WriteRegister} != LP_ZERO) &&
                 ({1'b0, bus.WriteRegister} <  LP_DEPTH);
   end

   // One-hot enable: only the addressed entry's enable asserts.
   always_comb begin
      w_we_dec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_we_dec[i] = w_commit && (bus.WriteRegister == ADDR_W'(i));
      end
   end

   // Storage array: one enable-gated WIDTH-bit register per entry, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_we_dec[i]) r_regs[i] <= bus.WriteData;
         end
      end
   end

   // WriteAck: registered copy of the commit condition.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_ack <= 1'b0;
      else       r_ack <= w_commit;
   end

   // Combinational read ports, each decoded independently.
   always_comb begin
      w_rd1 = f_read(bus.ReadRegister1);
      w_rd2 = f_read(bus.ReadRegister2);
   end

   assign bus.ReadData1 = w_rd1;
   assign bus.ReadData2 = w_rd2;
   assign bus.WriteAck  = r_ack;

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised general-purpose register file; successor to the fixed 64-bit enable register.
- Holds DEPTH words of WIDTH bits, with two combinational read ports and one clocked write port.
- Hard-wired zero register; optional same-cycle write-to-read bypass for the decode stage of the pipelined CPU.
- Storage is built from enable-gated D flip-flops, one WIDTH-bit enabled register per entry.

Parameters:
- WIDTH, 64, data width of each register.
- DEPTH, 32, number of registers. Legal range 2..32.
- ADDR_W, 5, address width. Must satisfy 2**ADDR_W >= DEPTH.
- ZERO_REG, 31, index that always reads 0 and ignores writes. Set to DEPTH to disable (no zero register).
- BYPASS, 1, 1 = a read of the address being written this cycle returns WriteData; 0 = returns the stored (old) value.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears every register to 0
- RegWrite  input  1  write enable, sampled at the rising edge of clk
- WriteRegister  input  ADDR_W  write address
- WriteData  input  WIDTH  write data
- ReadRegister1  input  ADDR_W  read address, port 1
- ReadRegister2  input  ADDR_W  read address, port 2
- ReadData1  output  WIDTH  read data, port 1 (combinational)
- ReadData2  output  WIDTH  read data, port 2 (combinational)
- WriteAck  output  1  registered; 1 for the one cycle after a write actually commits

Behaviour:
- Reset:
  - reset=1 immediately, without waiting for clk, forces all DEPTH registers to 0 and WriteAck to 0.
  - While reset is held, writes are ignored and both ReadData ports read 0.
  - A reset asserted mid-cycle during a pending write drops that write.
- Write:
  - At the rising edge of clk, reg[WriteRegister] <= WriteData only if all of these hold: RegWrite=1, WriteRegister != ZERO_REG, WriteRegister < DEPTH.
  - Only the addressed register's enable asserts; all other registers hold.
- WriteAck:
  - Registered copy of the commit condition above.
  - 0 for writes to ZERO_REG, to out-of-range addresses, or with RegWrite=0.
- Read, per port independently:
  - Address == ZERO_REG returns 0.
  - Address >= DEPTH returns 0.
  - Otherwise, if BYPASS=1 and RegWrite=1 and address == WriteRegister and WriteRegister != ZERO_REG, returns WriteData (pre-edge).
  - Otherwise returns reg[address].
- Latency:
  - Reads are combinational: 0 cycles.
  - A written value is visible from stored state on the cycle after the edge; with BYPASS=1 it is visible in the same cycle.
- Simultaneous events:
  - Both read ports on the same address return identical data.
  - Both ports reading the write address both see the bypass value.
  - A write and a read of different addresses do not interact.
- Width rule: WriteData is stored full-width, with no sign or zero manipulation.
- There is no state machine beyond the storage array and the WriteAck flop.

Test Plan:
1. Reset, then read every index on both ports -> all reads 0 and WriteAck=0. Assert reset=1 mid-cycle after writing 5000 to X3 -> ReadData1 for X3 goes 0 within the same cycle, before the next edge.
2. Write 5000 to X3; next cycle write 1010 to X4 with RegWrite=1; then read X3/X4 -> ReadData1=5000 and ReadData2=1010; WriteAck=1 on the cycle after each write.
3. With RegWrite=0 and WriteData=64'hDEAD_BEEF targeting X3 -> X3 stays 5000 and WriteAck=0.
4. Write 64'hFFFF_FFFF_FFFF_FFFF to X31 (ZERO_REG) -> ReadData1 for X31 = 0 and WriteAck=0.
5. BYPASS=1: write 77 to X7 while ReadRegister1=ReadRegister2=7 in the same cycle -> both ports show 77 before the edge. BYPASS=0 build, same stimulus -> both show the old value 0 before the edge and 77 after it.
6. DEPTH=16 build: write 9 to address 20 -> WriteAck=0, read of address 20 returns 0, and registers 0..15 are unchanged.
